// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM register SPI path
//
// Purpose: command decoder state encoding, command byte field positions and
// default widths used by spi_cmd_decoder.
// Ports: none (package).

package pwm_pkg;

  localparam int ADDR_W_DEFAULT = 6;
  localparam int DATA_W_DEFAULT = 8;

  // Command byte layout: bit7 selects write, bit6 reserved, bits[5:0] address.
  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_ADDR_MSB = 5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_HOLD  = 3'd2,
    WR_WAIT  = 3'd3,
    WR_ISSUE = 3'd4
  } state_t;

endpackage

// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - SPI byte stream to register read/write strobe decoder
//
// Purpose: turns command/data byte pairs from the SPI front-end into one-cycle
// read/write strobes for the PWM register block and returns read data for the
// SPI front-end to shift out during the second byte.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cs_active         chip select active (synchronised); low aborts
//   byte_sync         one-cycle pulse, data_in holds a received byte
//   data_in           received byte
//   data_out          byte to transmit on the next byte slot
//   read, write       one-cycle register strobes
//   addr              register address, held until the next command
//   data_read         combinational read data from the register block
//   data_write        write data, valid with write
//   proto_err         one-cycle pulse on dropped byte or aborted transaction

module spi_cmd_decoder
  import pwm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_active,
  input  logic              byte_sync,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_read,
  output logic [DATA_W-1:0] data_write,
  output logic              proto_err
);

  state_t            state, state_d;
  logic              read_d, write_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_write_d, data_out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      read       <= 1'b0;
      write      <= 1'b0;
      addr       <= '0;
      data_write <= '0;
      data_out   <= '0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_d;
      read       <= read_d;
      write      <= write_d;
      addr       <= addr_d;
      data_write <= data_write_d;
      data_out   <= data_out_d;
      proto_err  <= err_d;
    end
  end

  always_comb begin
    state_d      = state;
    read_d       = 1'b0;
    write_d      = 1'b0;
    err_d        = 1'b0;
    addr_d       = addr;
    data_write_d = data_write;
    data_out_d   = data_out;

    if (!cs_active) begin
      // Deselect wins over everything. A strobe already on the bus finishes
      // its cycle because read_d/write_d default low; only report an error
      // when a transaction was genuinely cut short.
      state_d = IDLE;
      err_d   = (state == WR_WAIT) || (state == RD_ISSUE) || (state == WR_ISSUE);
    end else begin
      case (state)
        IDLE: begin
          if (byte_sync) begin
            addr_d = data_in[CMD_ADDR_MSB:0];
            if (data_in[CMD_WR_BIT]) begin
              state_d = WR_WAIT;
            end else begin
              state_d = RD_ISSUE;
              read_d  = 1'b1;
            end
          end
        end
        RD_ISSUE: begin
          // data_read is valid only while read is high, so capture it here.
          data_out_d = data_read;
          state_d    = RD_HOLD;
          err_d      = byte_sync;
        end
        RD_HOLD: begin
          // Dummy byte clocked out with data_out; its content is ignored.
          if (byte_sync) state_d = IDLE;
        end
        WR_WAIT: begin
          if (byte_sync) begin
            data_write_d = data_in;
            write_d      = 1'b1;
            state_d      = WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          state_d = IDLE;
          err_d   = byte_sync;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb/tb_spi_cmd_decoder.sv - directed self-checking bench for spi_cmd_decoder

module tb_spi_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_active;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_read;
  logic [7:0] data_write;
  logic       proto_err;

  int total = 0;
  int bad   = 0;

  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  // Register block stand-in: reg 3 preloaded, everything else reads 0.
  logic [7:0] mem [64] = '{3: 8'hA5, default: 8'h00};

  assign data_read = mem[addr];

  always @(posedge clk) begin
    if (write) mem[addr] <= data_write;
  end

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write) wr_cnt <= wr_cnt + 1;
    if (read) rd_cnt <= rd_cnt + 1;
    if (proto_err) err_cnt <= err_cnt + 1;
    if (read && write) both_cnt <= both_cnt + 1;
  end

  spi_cmd_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_active  (cs_active),
    .byte_sync  (byte_sync),
    .data_in    (data_in),
    .data_out   (data_out),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .data_read  (data_read),
    .data_write (data_write),
    .proto_err  (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte for a single cycle; returns 1 time unit into the cycle
  // after the capturing edge.
  task automatic send(input logic [7:0] b);
    data_in   = b;
    byte_sync = 1'b1;
    @(posedge clk);
    #1;
    byte_sync = 1'b0;
    data_in   = 8'h00;
  endtask

  initial begin
    rst_n     = 1'b0;
    cs_active = 1'b1;
    byte_sync = 1'b0;
    data_in   = 8'h00;
    tick();
    tick();
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_addr", addr, 0);
    check("rst_dw", data_write, 0);
    check("rst_dout", data_out, 0);
    check("rst_err", proto_err, 0);
    rst_n = 1'b1;
    tick();

    // Reset while waiting for the data byte of a write.
    send(8'h85);
    check("mid_addr_pre", addr, 6'h05);
    #2 rst_n = 1'b0;
    #1;
    check("mid_addr_rst", addr, 0);
    check("mid_write_rst", write, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h00);
    check("mid_cmd_read", read, 1);
    check("mid_cmd_write", write, 0);
    tick();
    send(8'h00);

    // Write 0x34 to address 0.
    send(8'h80);
    check("wr_cmd_write", write, 0);
    check("wr_cmd_read", read, 0);
    send(8'h34);
    check("wr_write", write, 1);
    check("wr_addr", addr, 6'h00);
    check("wr_dw", data_write, 8'h34);
    check("wr_read", read, 0);
    tick();
    check("wr_write_off", write, 0);

    // Read address 3.
    send(8'h03);
    check("rd_read", read, 1);
    check("rd_addr", addr, 6'h03);
    tick();
    check("rd_read_off", read, 0);
    check("rd_dout", data_out, 8'hA5);
    send(8'h5A);
    check("rd_dout_dummy", data_out, 8'hA5);
    tick();
    check("rd_dout_held", data_out, 8'hA5);

    // Back-to-back write then read of the same register.
    send(8'h8A);
    send(8'h07);
    check("b2b_write", write, 1);
    check("b2b_addr", addr, 6'h0A);
    check("b2b_dw", data_write, 8'h07);
    tick();
    send(8'h0A);
    check("b2b_read", read, 1);
    check("b2b_raddr", addr, 6'h0A);
    tick();
    check("b2b_dout", data_out, 8'h07);
    send(8'h00);

    // Abort during WR_WAIT, then a stray byte while deselected.
    send(8'h81);
    cs_active = 1'b0;
    tick();
    check("abort_err", proto_err, 1);
    check("abort_write", write, 0);
    tick();
    check("abort_err_off", proto_err, 0);
    send(8'h55);
    check("cs_low_read", read, 0);
    check("cs_low_err", proto_err, 0);
    cs_active = 1'b1;
    tick();
    send(8'h81);
    send(8'hFF);
    check("abort_retry_write", write, 1);
    check("abort_retry_addr", addr, 6'h01);
    check("abort_retry_dw", data_write, 8'hFF);
    tick();

    // Reserved bit 6 ignored.
    send(8'h45);
    check("rsv_read", read, 1);
    check("rsv_addr", addr, 6'h05);
    check("rsv_err", proto_err, 0);
    tick();
    check("rsv_dout", data_out, 8'h00);
    send(8'h00);

    // Byte arriving during RD_ISSUE is dropped with an error.
    send(8'h03);
    send(8'h22);
    check("drop_err", proto_err, 1);
    check("drop_dout", data_out, 8'hA5);
    check("drop_read", read, 0);
    send(8'h00);
    send(8'h8A);
    send(8'h11);
    check("drop_after_write", write, 1);
    check("drop_after_dw", data_write, 8'h11);
    tick();
    tick();

    check("cnt_write", wr_cnt, 4);
    check("cnt_read", rd_cnt, 5);
    check("cnt_err", err_cnt, 2);
    check("cnt_both", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Decodes the byte stream from the SPI front-end into single-cycle read/write strobes for the PWM register block.
- A transaction is a command byte followed by one data byte.
- Write transactions deliver the data byte to the register file.
- Read transactions fetch the addressed register and present it on data_out, which the SPI front-end shifts out during the second byte.

Parameters:
- ADDR_W, 6, register address width (command byte bits [5:0])
- DATA_W, 8, byte width; fixed at 8, any other value is unsupported

Ports:
- clk  input  1  peripheral clock
- rst_n  input  1  asynchronous active-low reset
- cs_active  input  1  SPI chip-select active, synchronised to clk; low aborts any transaction
- byte_sync  input  1  one-cycle pulse: data_in holds a complete received byte
- data_in  input  8  byte received from SPI
- data_out  output  8  byte for SPI to transmit on the next byte slot
- read  output  1  register read strobe, one cycle
- write  output  1  register write strobe, one cycle
- addr  output  6  register address, valid with read/write and held until the next command
- data_read  input  8  combinational read data from the register block, valid while read=1
- data_write  output  8  write data, valid with write
- proto_err  output  1  one-cycle pulse: byte dropped or transaction aborted

Behaviour:
- One clock, one asynchronous active-low reset.
- All outputs are registered. Reset values: read=0, write=0, addr=0, data_write=0, data_out=0, proto_err=0, state=IDLE.
- Command byte format:
  - bit7 = 1 write, 0 read
  - bit6 = reserved, ignored
  - bits[5:0] = addr
- States: IDLE, RD_ISSUE, RD_HOLD, WR_WAIT, WR_ISSUE.
- IDLE: byte_sync at edge N → addr <= data_in[5:0].
  - If bit7=1: go to WR_WAIT.
  - If bit7=0: go to RD_ISSUE with read=1 during cycle N+1.
- RD_ISSUE (one cycle): read=1; at the end edge data_out <= data_read, read <= 0, go to RD_HOLD. data_out is stable from cycle N+2.
- RD_HOLD: data_out held. Next byte_sync (dummy byte, content ignored) → IDLE. data_out keeps its value until the next read capture.
- WR_WAIT: byte_sync at edge M → data_write <= data_in, go to WR_ISSUE with write=1 during cycle M+1.
- WR_ISSUE (one cycle): write=1, addr and data_write stable; next edge write <= 0, go to IDLE.
- Latency:
  - read strobe: 1 cycle after the command byte_sync
  - write strobe: 1 cycle after the data byte_sync
  - data_out valid: 2 cycles after the command byte_sync
- read and write are never high in the same cycle; each is high for exactly one cycle per transaction.
- cs_active low has priority over byte_sync. Any state goes to IDLE on the next edge, with read/write forced 0.
  - Abort from WR_WAIT, RD_ISSUE or WR_ISSUE → proto_err pulse.
  - An in-flight ISSUE strobe already asserted completes its cycle; no new strobe is issued.
- byte_sync while cs_active low is ignored and raises no error.
- byte_sync during RD_ISSUE or WR_ISSUE is dropped, proto_err pulses, and the state transition proceeds normally.
- Writes to unmapped addresses are issued anyway; the register block ignores them. Reads return whatever data_read supplies (0 for unmapped).
- Back-to-back transactions are supported: a command byte_sync may arrive on the first IDLE cycle.

Decomposition:
- Shared package pwm_pkg holds:
  - state enum (IDLE, RD_ISSUE, RD_HOLD, WR_WAIT, WR_ISSUE)
  - CMD_WR_BIT=7, CMD_ADDR_MSB=5
  - ADDR_W and DATA_W defaults
- Single module, no sub-module; the FSM and output registers are tightly coupled.

Test Plan:
- Reset mid-write (rst_n low during WR_WAIT) → all outputs 0, state IDLE; a subsequent byte 0x00 is treated as a command.
- Write: bytes 0x80, 0x34 → exactly one cycle of write=1 with addr=0x00, data_write=0x34, one cycle after the second byte_sync; read stays 0.
- Read: command 0x03 with data_read model returning 0xA5 for addr 3 → read=1 one cycle after byte_sync, addr=0x03; data_out=0xA5 from the following cycle and held through the dummy byte.
- Back-to-back: 0x8A,0x07 then immediately 0x0A → write to addr 0x0A with 0x07, then read of 0x0A; data_out=0x07 via the register model.
- Abort: 0x81, then cs_active low before the data byte → no write strobe, one proto_err pulse; the next 0x81,0xFF writes 0xFF to addr 1.
- Reserved bit: command 0x45 → read of addr 0x05 (bit6 ignored), no error.
